// File: rtl/serial_frame_tx_if.sv
// Handshake and serial-line bundle for serial_frame_tx.
//   data_in : word to transmit (sampled at the accept edge)
//   valid   : upstream has a word on data_in
//   ready   : transmitter can accept a word this cycle
//   out     : serial line, idles high
//   busy    : frame in progress (always ~ready)
//   done    : one-cycle pulse when a frame completes
// master = word source, slave = transmitter.
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             out;
    logic             busy;
    logic             done;

    modport master (
        output data_in, valid,
        input  ready, out, busy, done
    );

    modport slave (
        input  data_in, valid,
        output ready, out, busy, done
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter.
// Frame on tx.out: start (0), WIDTH data bits LSB first, optional parity,
// stop (1); each bit held CLKS_PER_BIT cycles. All outputs are registered.
// Ports:
//   clk   : system clock, all state changes on posedge
//   reset : asynchronous, active-high
//   tx    : slave side of serial_frame_tx_if (data_in/valid in,
//           ready/out/busy/done out)
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | line high, ready for a word
// S_START  | driving start bit (0)
// S_DATA   | driving shift_q[0], bit index in bit_q
// S_PARITY | driving the parity bit latched at accept
// S_STOP   | driving stop bit (1); done pulses as it ends
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic               clk,
    input  logic               reset,
    serial_frame_tx_if.slave   tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             out_q, out_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             bit_end;

    // The output registers are loaded with the value of the bit that starts
    // on this edge, so out changes exactly on bit boundaries with no
    // combinational path from the inputs.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        out_d   = out_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        bit_end = (cyc_q == CYC_LAST);

        case (state_q)
            S_IDLE: begin
                out_d   = 1'b1;
                ready_d = 1'b1;
                cyc_d   = '0;
                bit_d   = '0;
                if (tx.valid) begin
                    shift_d = tx.data_in;
                    par_d   = (^tx.data_in) ^ (PARITY_ODD != 0);
                    state_d = S_START;
                    out_d   = 1'b0;
                    ready_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    out_d   = shift_q[0];
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            out_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        out_d = shift_d[0];
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                    out_d   = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_IDLE;
                    out_d   = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = '0;
                bit_d   = '0;
                out_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign tx.out   = out_q;
    assign tx.ready = ready_q;
    assign tx.busy  = ~ready_q;
    assign tx.done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: four instances with different parameter sets,
// checked cycle by cycle against a frame model built as a list of bits.
module tb_serial_frame_tx;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    // per-instance parameters: 0 default, 1 odd parity, 2 no parity, 3 one clk/bit
    int cpb  [4] = '{4, 4, 4, 1};
    int pen  [4] = '{1, 1, 0, 1};
    int podd [4] = '{0, 1, 0, 0};

    serial_frame_tx_if #(.WIDTH(8)) if0 ();
    serial_frame_tx_if #(.WIDTH(8)) if1 ();
    serial_frame_tx_if #(.WIDTH(8)) if2 ();
    serial_frame_tx_if #(.WIDTH(8)) if3 ();

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0))
        u0 (.clk(clk), .reset(reset), .tx(if0));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1))
        u1 (.clk(clk), .reset(reset), .tx(if1));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0))
        u2 (.clk(clk), .reset(reset), .tx(if2));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0))
        u3 (.clk(clk), .reset(reset), .tx(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {out, ready, busy, done}
    function automatic logic [3:0] obs(int i);
        case (i)
            0:       return {if0.out, if0.ready, if0.busy, if0.done};
            1:       return {if1.out, if1.ready, if1.busy, if1.done};
            2:       return {if2.out, if2.ready, if2.busy, if2.done};
            default: return {if3.out, if3.ready, if3.busy, if3.done};
        endcase
    endfunction

    task automatic set_in(int i, logic v, logic [7:0] d);
        case (i)
            0:       begin if0.valid = v; if0.data_in = d; end
            1:       begin if1.valid = v; if1.data_in = d; end
            2:       begin if2.valid = v; if2.data_in = d; end
            default: begin if3.valid = v; if3.data_in = d; end
        endcase
    endtask

    task automatic check(string tag, logic [3:0] o, logic [3:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed={out,ready,busy,done}=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic accept(int i, logic [7:0] d);
        @(negedge clk);
        set_in(i, 1'b1, d);
        @(posedge clk);
        #1;
    endtask

    // Entered at #1 after the accept edge. mode 0: drop valid at once,
    // mode 1: keep valid high and present next_d, mode 2: scramble inputs
    // every cycle of the frame then drop valid at the done edge.
    task automatic frame_run(int i, logic [7:0] d, int mode, logic [7:0] next_d);
        bit q[$];
        int c;
        int len;
        c = cpb[i];
        q.push_back(1'b0);
        for (int b = 0; b < 8; b++) q.push_back(d[b]);
        if (pen[i] != 0) q.push_back((^d) ^ (podd[i] != 0));
        q.push_back(1'b1);
        len = q.size() * c;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (k < len)
                check($sformatf("i%0d_d%02h_k%0d", i, d, k), obs(i), {q[k / c], 3'b010});
            else
                check($sformatf("i%0d_d%02h_done", i, d), obs(i), 4'b1101);
            if (mode == 0 && k == 0) set_in(i, 1'b0, 8'($urandom));
            if (mode == 1 && k == 0) set_in(i, 1'b1, next_d);
            if (mode == 2 && k < len) set_in(i, 1'($urandom), 8'($urandom));
            if (mode == 2 && k == len) set_in(i, 1'b0, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         ri;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) set_in(i, 1'b0, 8'h00);
        #2;
        for (int i = 0; i < 4; i++) check($sformatf("reset_i%0d", i), obs(i), 4'b1100);
        @(negedge clk);
        reset = 1'b0;

        // idle with valid low
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) check($sformatf("idle_i%0d_n%0d", i, n), obs(i), 4'b1100);
        end

        // single frame, defaults
        accept(0, 8'hA5);
        frame_run(0, 8'hA5, 0, 8'h00);

        // parity variants
        accept(0, 8'h07);
        frame_run(0, 8'h07, 0, 8'h00);
        accept(1, 8'h07);
        frame_run(1, 8'h07, 0, 8'h00);
        accept(2, 8'h07);
        frame_run(2, 8'h07, 0, 8'h00);

        // back-to-back with valid held high: second accept one edge after done
        accept(0, 8'h3C);
        frame_run(0, 8'h3C, 1, 8'hC3);
        @(posedge clk);
        #1;
        frame_run(0, 8'hC3, 0, 8'h00);

        // reset during data bit 3 of 8'hFF, asserted between edges
        accept(0, 8'hFF);
        set_in(0, 1'b0, 8'h00);
        repeat (17) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_async", obs(0), 4'b1100);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset_n%0d", n), obs(0), 4'b1100);
        end
        accept(0, 8'h55);
        frame_run(0, 8'h55, 0, 8'h00);

        // one clock per bit with inputs scrambled during the frame
        accept(3, 8'h81);
        frame_run(3, 8'h81, 2, 8'h00);

        // random words on random instances
        for (int r = 0; r < 10; r++) begin
            ri = int'($urandom_range(0, 3));
            rd = 8'($urandom);
            accept(ri, rd);
            frame_run(ri, rd, 2, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
